// File: rtl/mbox_fifo_apb.sv
// Mailbox endpoint: APB register front-end with TX/RX word FIFOs, level interrupts
// and an abort handshake toward the peer CPU complex over valid/ready/done/abort.
module mbox_fifo_apb #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic          pclk,
  input  logic          resetn,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [11:0]   paddr,
  input  logic [31:0]   pwdata,
  output logic [31:0]   prdata,
  output logic          pready,
  output logic [DW-1:0] mbox_w_dat,
  output logic          mbox_w_valid,
  input  logic          mbox_w_ready,
  output logic          mbox_w_done,
  input  logic [DW-1:0] mbox_r_dat,
  input  logic          mbox_r_valid,
  output logic          mbox_r_ready,
  input  logic          mbox_r_done,
  output logic          mbox_w_abort,
  input  logic          mbox_r_abort,
  output logic [3:0]    irq
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_LOCAL, ST_ACK} state_t;

  state_t            state, state_nxt;
  logic [DW-1:0]     tx_mem [DEPTH];
  logic [DW-1:0]     rx_mem [DEPTH];
  logic [AW-1:0]     tx_wp, tx_rp, rx_wp, rx_rp;
  logic [LW-1:0]     tx_level, rx_level, rx_level_nxt, rxthr;
  logic [3:0]        ie, ip, ip_set, ip_clr;
  logic              tx_err, rx_err, abort_ack, done_pend, w_done_q;
  logic              flush, set_abort_done, set_abort_init;

  logic wr_en, rd_en;
  logic a_wdata, a_rdata, a_status, a_ie, a_ip, a_rxthr, a_abort, a_done;
  logic idle, tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, tx_push_err, rx_push, rx_pop, rx_pop_err;
  logic abort_wr, abort_start, done_wr, done_fire, thr_hit, status_rd;
  logic unused_bits;

  assign wr_en    = psel & penable & pwrite;
  assign rd_en    = psel & penable & ~pwrite;
  assign a_wdata  = (paddr == 12'h000);
  assign a_rdata  = (paddr == 12'h004);
  assign a_status = (paddr == 12'h008);
  assign a_ie     = (paddr == 12'h00C);
  assign a_ip     = (paddr == 12'h010);
  assign a_rxthr  = (paddr == 12'h014);
  assign a_abort  = (paddr == 12'h018);
  assign a_done   = (paddr == 12'h01C);

  assign idle     = (state == ST_IDLE);
  assign tx_full  = (tx_level == LW'(DEPTH));
  assign tx_empty = (tx_level == '0);
  assign rx_full  = (rx_level == LW'(DEPTH));
  assign rx_empty = (rx_level == '0);

  // Outside IDLE the APB side sees TX as full and RX as empty
  assign tx_push     = wr_en & a_wdata & ~tx_full & idle;
  assign tx_push_err = wr_en & a_wdata & ~(~tx_full & idle);
  assign tx_pop      = mbox_w_valid & mbox_w_ready;
  assign rx_push     = mbox_r_valid & mbox_r_ready;
  assign rx_pop      = rd_en & a_rdata & ~rx_empty & idle;
  assign rx_pop_err  = rd_en & a_rdata & ~(~rx_empty & idle);

  assign abort_wr    = wr_en & a_abort & pwdata[0];
  assign abort_start = abort_wr & idle;
  assign done_wr     = wr_en & a_done & pwdata[0];
  assign done_fire   = done_pend & tx_empty & idle;
  assign status_rd   = rd_en & a_status;

  assign rx_level_nxt = rx_level + LW'(rx_push) - LW'(rx_pop);
  assign thr_hit = (rxthr != '0) && (rx_level < rxthr) && (rx_level_nxt >= rxthr) && !flush;

  assign ip_set = {tx_push_err | rx_pop_err, set_abort_done, set_abort_init, mbox_r_done | thr_hit};
  assign ip_clr = (wr_en & a_ip) ? pwdata[3:0] : 4'h0;

  assign mbox_w_dat   = tx_mem[tx_rp];
  assign mbox_w_valid = ~tx_empty & idle;
  assign mbox_r_ready = resetn & ~rx_full & idle;
  assign mbox_w_abort = (state == ST_LOCAL) | (state == ST_ACK);
  assign mbox_w_done  = w_done_q;
  assign irq          = ip & ie;
  assign pready       = 1'b1;
  assign unused_bits  = ^pwdata;

  always_comb begin
    state_nxt      = state;
    flush          = 1'b0;
    set_abort_done = 1'b0;
    set_abort_init = 1'b0;
    case (state)
      ST_IDLE: begin
        if (abort_wr) begin
          state_nxt = ST_LOCAL;
          flush     = 1'b1;
        end else if (mbox_r_abort) begin
          state_nxt      = ST_ACK;
          flush          = 1'b1;
          set_abort_init = 1'b1;
        end
      end
      ST_LOCAL: begin
        if (mbox_r_abort) begin
          state_nxt      = ST_IDLE;
          set_abort_done = 1'b1;
        end
      end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge pclk) begin
    if (tx_push) tx_mem[tx_wp] <= pwdata[DW-1:0];
    if (rx_push) rx_mem[rx_wp] <= mbox_r_dat;
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_level <= '0;
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_level <= '0;
    end else if (flush) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_level <= '0;
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_level <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      tx_level <= tx_level + LW'(tx_push) - LW'(tx_pop);
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      rx_level <= rx_level_nxt;
    end
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      ie        <= '0;
      ip        <= '0;
      rxthr     <= LW'(1);
      tx_err    <= 1'b0;
      rx_err    <= 1'b0;
      abort_ack <= 1'b0;
      done_pend <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (wr_en & a_ie)    ie    <= pwdata[3:0];
      if (wr_en & a_rxthr) rxthr <= pwdata[LW-1:0];
      ip       <= (ip & ~ip_clr) | ip_set;
      tx_err   <= (tx_err & ~(wr_en & a_status & pwdata[4])) | tx_push_err;
      rx_err   <= (rx_err & ~(wr_en & a_status & pwdata[5])) | rx_pop_err;
      w_done_q <= done_fire;
      // A DONE write landing while one is pending or firing merges into it
      if (flush | done_fire) done_pend <= 1'b0;
      else if (done_wr)      done_pend <= 1'b1;
      if (set_abort_done)                abort_ack <= 1'b1;
      else if (abort_start | status_rd)  abort_ack <= 1'b0;
    end
  end

  function automatic logic [7:0] lvl8(input logic [LW-1:0] l);
    logic [8:0] w;
    w = 9'(l);
    return w[8] ? 8'hFF : w[7:0];
  endfunction

  always_comb begin
    prdata = '0;
    if (rd_en) begin
      case (paddr)
        12'h004: prdata = rx_pop ? 32'(rx_mem[rx_rp]) : '0;
        12'h008: prdata = {8'h00, lvl8(rx_level), lvl8(tx_level), 2'b00, rx_err, tx_err,
                           abort_ack, state == ST_LOCAL, ~tx_full, ~rx_empty};
        12'h00C: prdata = {28'h0, ie};
        12'h010: prdata = {28'h0, ip};
        12'h014: prdata = 32'(rxthr);
        default: prdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mbox_fifo_apb.sv
// Directed bench for mbox_fifo_apb (DEPTH=4): FIFO overflow/underflow, threshold
// interrupt, done pulse, local/peer/simultaneous abort and asynchronous reset.
module tb_mbox_fifo_apb;

  logic        pclk, resetn;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready;
  logic [31:0] mbox_w_dat, mbox_r_dat;
  logic        mbox_w_valid, mbox_w_ready, mbox_w_done;
  logic        mbox_r_valid, mbox_r_ready, mbox_r_done;
  logic        mbox_w_abort, mbox_r_abort;
  logic [3:0]  irq;

  int unsigned checks = 0;
  int unsigned errors = 0;

  mbox_fifo_apb #(.DW(32), .DEPTH(4)) dut (
    .pclk(pclk), .resetn(resetn),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .mbox_w_dat(mbox_w_dat), .mbox_w_valid(mbox_w_valid), .mbox_w_ready(mbox_w_ready),
    .mbox_w_done(mbox_w_done),
    .mbox_r_dat(mbox_r_dat), .mbox_r_valid(mbox_r_valid), .mbox_r_ready(mbox_r_ready),
    .mbox_r_done(mbox_r_done),
    .mbox_w_abort(mbox_w_abort), .mbox_r_abort(mbox_r_abort),
    .irq(irq)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    @(posedge pclk); #1;
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
    @(posedge pclk); #1;
    psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    d = prdata;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int          cnt, first;

    resetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; mbox_w_ready = 1'b0; mbox_r_dat = '0;
    mbox_r_valid = 1'b0; mbox_r_done = 1'b0; mbox_r_abort = 1'b0;

    // reset state
    repeat (3) @(posedge pclk);
    #2;
    chk("rst_w_valid", 32'(mbox_w_valid), 0);
    chk("rst_w_done",  32'(mbox_w_done), 0);
    chk("rst_w_abort", 32'(mbox_w_abort), 0);
    chk("rst_r_ready", 32'(mbox_r_ready), 0);
    chk("rst_irq",     32'(irq), 0);
    chk("rst_prdata",  prdata, 0);
    @(posedge pclk); #1;
    resetn = 1'b1;
    apb_read(12'h008, rd); chk("init_status", rd, 32'h2);
    apb_read(12'h014, rd); chk("init_rxthr", rd, 32'h1);

    // TX overflow
    for (int i = 0; i < 5; i++) apb_write(12'h000, 32'hA1 + 32'(i));
    apb_read(12'h008, rd); chk("tx_full_status", rd, 32'h0000_0410);
    apb_read(12'h010, rd); chk("tx_err_ip", rd, 32'h8);
    chk("tx_irq_masked", 32'(irq), 0);
    mbox_w_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      chk("tx_dat", mbox_w_dat, 32'hA1 + 32'(i));
      chk("tx_valid", 32'(mbox_w_valid), 1);
    end
    @(negedge pclk);
    chk("tx_drained", 32'(mbox_w_valid), 0);
    @(posedge pclk); #1;
    mbox_w_ready = 1'b0;
    apb_write(12'h008, 32'h30);
    apb_write(12'h010, 32'hF);
    apb_read(12'h008, rd); chk("tx_clr_status", rd, 32'h2);

    // RX threshold interrupt and underflow
    apb_write(12'h014, 32'h2);
    apb_write(12'h00C, 32'h1);
    for (int i = 0; i < 3; i++) begin
      mbox_r_dat = 32'hB1 + 32'(i);
      mbox_r_valid = 1'b1;
      @(negedge pclk);
      chk("rx_thr_irq", 32'(irq), (i >= 2) ? 32'h1 : 32'h0);
      @(posedge pclk); #1;
    end
    mbox_r_valid = 1'b0;
    apb_read(12'h008, rd); chk("rx_status", rd, 32'h0003_0003);
    for (int i = 0; i < 3; i++) begin
      apb_read(12'h004, rd); chk("rx_data", rd, 32'hB1 + 32'(i));
    end
    apb_read(12'h004, rd); chk("rx_underflow_data", rd, 32'h0);
    apb_read(12'h008, rd); chk("rx_err_status", rd, 32'h22);
    apb_read(12'h010, rd); chk("rx_ip", rd, 32'h9);
    chk("rx_irq", 32'(irq), 32'h1);
    apb_write(12'h008, 32'h30);
    apb_write(12'h010, 32'hF);
    apb_write(12'h00C, 32'h0);

    // done pulse after queued words drain
    apb_write(12'h000, 32'hC1);
    apb_write(12'h000, 32'hC2);
    apb_write(12'h01C, 32'h1);
    @(negedge pclk);
    chk("done_early", 32'(mbox_w_done), 0);
    @(posedge pclk); #1;
    mbox_w_ready = 1'b1;
    cnt = 0; first = -1;
    for (int n = 0; n < 8; n++) begin
      @(negedge pclk);
      if (mbox_w_done) begin
        cnt++;
        if (first < 0) first = n;
      end
    end
    chk("done_count", 32'(cnt), 1);
    chk("done_cycle", 32'(first), 3);
    @(posedge pclk); #1;
    mbox_w_ready = 1'b0;

    // local abort with RX half full
    mbox_r_valid = 1'b1; mbox_r_dat = 32'hD1;
    @(posedge pclk); #1;
    mbox_r_dat = 32'hD2;
    @(posedge pclk); #1;
    mbox_r_valid = 1'b0;
    apb_write(12'h010, 32'hF);
    apb_write(12'h018, 32'h1);
    chk("la_w_abort", 32'(mbox_w_abort), 1);
    chk("la_r_ready", 32'(mbox_r_ready), 0);
    apb_read(12'h008, rd); chk("la_status", rd, 32'h6);
    @(posedge pclk); #1;
    mbox_r_abort = 1'b1;
    @(negedge pclk);
    chk("la_hold", 32'(mbox_w_abort), 1);
    @(posedge pclk); #1;
    mbox_r_abort = 1'b0;
    chk("la_release", 32'(mbox_w_abort), 0);
    apb_read(12'h010, rd); chk("la_ip", rd, 32'h4);
    apb_read(12'h008, rd); chk("la_ack", rd, 32'hA);
    apb_read(12'h008, rd); chk("la_ack_clr", rd, 32'h2);

    // peer abort with TX nonempty
    apb_write(12'h010, 32'hF);
    apb_write(12'h000, 32'hE1);
    @(negedge pclk);
    chk("pa_pre_valid", 32'(mbox_w_valid), 1);
    @(posedge pclk); #1;
    mbox_r_abort = 1'b1;
    @(negedge pclk);
    chk("pa_pre_abort", 32'(mbox_w_abort), 0);
    @(posedge pclk); #1;
    mbox_r_abort = 1'b0;
    @(negedge pclk);
    chk("pa_abort", 32'(mbox_w_abort), 1);
    chk("pa_valid_ack", 32'(mbox_w_valid), 0);
    @(negedge pclk);
    chk("pa_abort_end", 32'(mbox_w_abort), 0);
    chk("pa_flushed", 32'(mbox_w_valid), 0);
    chk("pa_r_ready", 32'(mbox_r_ready), 1);
    apb_read(12'h010, rd); chk("pa_ip", rd, 32'h2);
    apb_read(12'h008, rd); chk("pa_status", rd, 32'h2);

    // ABORT write and peer abort in the same cycle
    apb_write(12'h010, 32'hF);
    @(posedge pclk); #1;
    psel = 1'b1; pwrite = 1'b1; paddr = 12'h018; pwdata = 32'h1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    mbox_r_abort = 1'b1;
    @(negedge pclk);
    chk("sim_pre", 32'(mbox_w_abort), 0);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge pclk);
    chk("sim_local", 32'(mbox_w_abort), 1);
    @(posedge pclk); #1;
    mbox_r_abort = 1'b0;
    @(negedge pclk);
    chk("sim_idle", 32'(mbox_w_abort), 0);
    apb_read(12'h010, rd); chk("sim_ip", rd, 32'h4);
    apb_read(12'h008, rd); chk("sim_status", rd, 32'hA);

    // asynchronous reset mid-transfer
    apb_write(12'h010, 32'hF);
    apb_write(12'h00C, 32'hF);
    apb_write(12'h000, 32'hF1);
    apb_read(12'h004, rd); chk("ar_empty_read", rd, 32'h0);
    @(negedge pclk);
    chk("ar_pre_valid", 32'(mbox_w_valid), 1);
    chk("ar_pre_irq", 32'(irq), 32'h8);
    @(posedge pclk); #3;
    resetn = 1'b0;
    #1;
    chk("ar_w_valid", 32'(mbox_w_valid), 0);
    chk("ar_irq", 32'(irq), 0);
    chk("ar_r_ready", 32'(mbox_r_ready), 0);
    chk("ar_w_abort", 32'(mbox_w_abort), 0);
    @(posedge pclk); #1;
    resetn = 1'b1;
    apb_read(12'h008, rd); chk("ar_status", rd, 32'h2);
    apb_read(12'h00C, rd); chk("ar_ie", rd, 32'h0);
    apb_read(12'h014, rd); chk("ar_rxthr", rd, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mbox_fifo_apb.md
Name: mbox_fifo_apb

Overview:
- Parametrised, single-clock mailbox endpoint. Adds TX/RX word FIFOs of configurable depth and width, level-based interrupts with enable/pending registers, and an explicit abort state machine.
- The APB side lets software queue outbound words and drain inbound words.
- The link side speaks the mailbox valid/ready/done/abort protocol to the peer CPU complex.

Parameters:
- DW, 32, data word width (8..32).
- DEPTH, 8, entries per FIFO (power of two, 2..256).
- LW, $clog2(DEPTH+1), level counter width (derived, not overridable).

Ports:
- pclk  in  1  single clock for APB and link.
- resetn  in  1  asynchronous active-low reset.
- psel, penable, pwrite  in  1 each  APB control.
- paddr  in  12  APB byte address.
- pwdata  in  32  APB write data.
- prdata  out  32  APB read data.
- pready  out  1  tied 1 (zero wait states).
- mbox_w_dat  out  DW  TX FIFO head.
- mbox_w_valid  out  1  TX word valid.
- mbox_w_ready  in  1  peer accepts TX word.
- mbox_w_done  out  1  end-of-packet pulse.
- mbox_r_dat  in  DW  inbound word.
- mbox_r_valid  in  1  inbound valid.
- mbox_r_ready  out  1  RX can accept.
- mbox_r_done  in  1  peer end-of-packet pulse.
- mbox_w_abort  out  1  local abort / abort ack.
- mbox_r_abort  in  1  peer abort.
- irq  out  4  {error, abort_done, abort_init, available}; equals IP & IE.

Behaviour:
- Access strobes: APB write = psel&penable&pwrite; read = psel&penable&!pwrite. Unmapped addresses read 0 and ignore writes.
- Register map:
  - 0x00 WDATA (W): push pwdata[DW-1:0] into TX.
  - 0x04 RDATA (R): return RX head zero-extended, then pop.
  - 0x08 STATUS (R; W1C on [5:4]): [0] rx_avail, [1] tx_free, [2] abort_in_progress, [3] abort_ack, [4] tx_err, [5] rx_err, [15:8] tx_level, [23:16] rx_level.
  - 0x0C IE (RW, 4b).
  - 0x10 IP (R, W1C, 4b).
  - 0x14 RXTHR (RW, LW bits, reset 1).
  - 0x18 ABORT (W, bit0=1 starts abort).
  - 0x1C DONE (W, bit0=1 requests w_done).
- FIFO full/empty are sampled at the start of the cycle, before that cycle's pop/push:
  - WDATA write while TX full: word dropped, tx_err set, IP.error set.
  - RDATA read while RX empty: returns 0, no pop, rx_err set, IP.error set.
  - Simultaneous push and pop on a non-full/non-empty FIFO: level unchanged.
- TX link:
  - mbox_w_valid = !tx_empty && state==IDLE.
  - Pop on w_valid&&w_ready.
  - mbox_w_dat is stable while valid and not accepted.
- RX link:
  - mbox_r_ready = !rx_full && state==IDLE.
  - Push on r_valid&&r_ready.
- Done:
  - A DONE write sets done_pend.
  - mbox_w_done pulses exactly 1 cycle, registered, in the first cycle where done_pend && tx_empty && state==IDLE. That pulse clears done_pend.
  - A second DONE write while pending is merged.
- IP.available sets on mbox_r_done, or when rx_level crosses from < RXTHR to >= RXTHR. RXTHR=0 disables the threshold term.
- Abort FSM states: IDLE, LOCAL (abort_in_progress=1), ACK.
  - IDLE -> LOCAL on ABORT write. Actions: flush both FIFOs, clear done_pend, assert mbox_w_abort.
  - LOCAL -> IDLE when mbox_r_abort=1. Actions: deassert mbox_w_abort, set IP.abort_done, set abort_ack=1.
  - IDLE -> ACK when mbox_r_abort=1 and no ABORT write that cycle. Actions: flush both FIFOs, set IP.abort_init, assert mbox_w_abort for 1 cycle.
  - ACK -> IDLE unconditionally.
  - ABORT write and mbox_r_abort rising in the same cycle: take IDLE->LOCAL; LOCAL completes on the next cycle because r_abort is still high.
  - ABORT write in LOCAL or ACK: ignored.
  - abort_ack clears on the next ABORT write or on a STATUS read.
  - Link valid/ready are 0 outside IDLE.
  - APB WDATA/RDATA accesses outside IDLE behave as full/empty (error path).
- Reset: asynchronous; all registers clear immediately.
  - FIFOs empty, FSM IDLE, IE=0, IP=0, errors 0, RXTHR=1.
  - Outputs: mbox_w_valid=0, mbox_w_done=0, mbox_w_abort=0, mbox_r_ready=0 (while resetn low), irq=0, prdata=0.
- Latency:
  - WDATA write to mbox_w_valid: 1 cycle.
  - r_valid&&r_ready to rx_avail: 1 cycle.
  - Event to irq: 1 cycle.

Test Plan:
- DEPTH=4, w_ready=0; write 5 words 0xA1..0xA5 -> tx_level=4, 0xA5 dropped, tx_err=1, IP=4'b1000. Then w_ready=1 -> 0xA1..0xA4 emitted in order on consecutive cycles.
- Peer pushes 3 words with RXTHR=2, IE=1 -> irq[0] rises 1 cycle after the 2nd push. Reads return words in order; a 4th read returns 0 and sets rx_err.
- DONE write with 2 TX words queued -> mbox_w_done is a single pulse only after the 2nd word accepted; none emitted earlier.
- Local ABORT with RX half full -> levels 0 next cycle, mbox_w_abort=1 until r_abort=1; then IP.abort_done=1 and abort_ack=1.
- Peer r_abort with TX nonempty -> FIFOs flushed, one-cycle mbox_w_abort pulse, IP.abort_init=1. Simultaneous ABORT write plus r_abort -> LOCAL then IDLE within 2 cycles.
- Assert resetn low mid-transfer with w_valid=1 -> w_valid, levels, irq all 0 immediately, without waiting for a clock edge.
